// File: rtl/pack_512_wr_pkg.sv
// Shared constants and elaboration helpers for the 512-bit write-side packer.
package pack_512_wr_pkg;

  // Width of the downstream FIFO word.
  localparam int OUT_W = 512;

  // Input widths that divide OUT_W into a power-of-two lane count.
  function automatic bit din_w_legal(input int w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64) || (w == 128) || (w == 256);
  endfunction

  // Number of input words per packed word.
  function automatic int lanes_of(input int w);
    return OUT_W / w;
  endfunction

  // Width of the lane index.
  function automatic int lane_w_of(input int w);
    return $clog2(OUT_W / w);
  endfunction

endpackage

// File: rtl/pack_512_wr.sv
// Packs little-endian DIN_W-bit words into 512-bit FIFO words, zero-pads
// partial words at frame end and reports the word count of each frame.
module pack_512_wr
  import pack_512_wr_pkg::*;
#(
  parameter int DIN_W = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIN_W-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT_W-1:0] fifo_din,
  output logic             fifo_wr_en,
  input  logic             fifo_full,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_words
);

  localparam int LANES  = lanes_of(DIN_W);
  localparam int LANE_W = lane_w_of(DIN_W);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  generate
    if (!din_w_legal(DIN_W)) begin : g_bad_din_w
      $error("pack_512_wr: DIN_W=%0d must be one of 8,16,32,64,128,256", DIN_W);
    end
  endgenerate

  logic [LANE_W-1:0] lane_reg;
  logic [OUT_W-1:0]  asm_reg;
  logic [OUT_W-1:0]  asm_merged;
  logic [OUT_W-1:0]  pend_reg;
  logic              pend_v_reg;
  logic              pend_last_reg;
  logic [CNT_W-1:0]  fcnt_reg;
  logic [CNT_W-1:0]  fcnt_inc;
  logic [CNT_W-1:0]  frame_words_reg;
  logic              frame_done_reg;
  logic              accept;
  logic              complete;
  logic              wr_fire;

  // A held pend blocks every input word, completing or not, so the
  // ready rule does not depend on the current lane.
  assign in_ready   = ~pend_v_reg | ~fifo_full;
  assign accept     = in_valid & in_ready;
  assign complete   = accept & ((lane_reg == LAST_LANE) | in_last);
  assign wr_fire    = pend_v_reg & ~fifo_full;
  assign fifo_wr_en = wr_fire;
  assign fifo_din   = pend_reg;
  assign frame_done  = frame_done_reg;
  assign frame_words = frame_words_reg;
  assign fcnt_inc   = (&fcnt_reg) ? fcnt_reg : fcnt_reg + CNT_W'(1);

  // Assembly word with the incoming word dropped into the current lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign asm_merged[gi*DIN_W +: DIN_W] =
      (lane_reg == LANE_W'(gi)) ? in_data : asm_reg[gi*DIN_W +: DIN_W];
  end

  // Lane fill, hand-off of completed words to pend, and pend release on write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_reg      <= '0;
      asm_reg       <= '0;
      pend_reg      <= '0;
      pend_v_reg    <= 1'b0;
      pend_last_reg <= 1'b0;
    end else begin
      if (complete) begin
        // Clearing asm here is what zero-pads the next partial word.
        pend_reg      <= asm_merged;
        pend_last_reg <= in_last;
        lane_reg      <= '0;
        asm_reg       <= '0;
      end else if (accept) begin
        asm_reg  <= asm_merged;
        lane_reg <= lane_reg + LANE_W'(1);
      end
      // A reload in the same cycle as a write keeps pend valid.
      if (complete) begin
        pend_v_reg <= 1'b1;
      end else if (wr_fire) begin
        pend_v_reg <= 1'b0;
      end
    end
  end

  // Per-frame write counter and the frame-done report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_reg        <= '0;
      frame_words_reg <= '0;
      frame_done_reg  <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (wr_fire) begin
        if (pend_last_reg) begin
          frame_words_reg <= fcnt_inc;
          fcnt_reg        <= '0;
          frame_done_reg  <= 1'b1;
        end else begin
          fcnt_reg <= fcnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pack_512_wr.sv
// Directed and randomized checks of pack_512_wr at DIN_W=64 and DIN_W=8
// against a word-list reference model of the packing rules.
module tb_pack_512_wr;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [63:0]       dat   [2];
  logic [1:0]        valid;
  logic [1:0]        last;
  logic [1:0]        ready;
  logic [511:0]      din   [2];
  logic [1:0]        wr;
  logic [1:0]        full;
  logic [1:0]        fd;
  logic [15:0]       fw    [2];

  int checks   = 0;
  int failures = 0;

  // Reference model state per instance (0: 64-bit input, 1: 8-bit input).
  logic [511:0] acc      [2];
  int           nlane    [2];
  bit           exp_v    [2];
  logic [511:0] exp_word [2];
  bit           exp_last [2];
  bit           fd_due   [2];
  logic [15:0]  exp_fw   [2];
  int           wcnt     [2];
  bit           accepted [2];
  int           nwr_dut  [2];
  int           full_hold[2];
  bit           toggle_full[2];
  logic [511:0] wlog0[$];

  always #5 clk = ~clk;

  pack_512_wr #(.DIN_W(64), .CNT_W(16)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_data(dat[0]), .in_valid(valid[0]),
    .in_last(last[0]), .in_ready(ready[0]), .fifo_din(din[0]),
    .fifo_wr_en(wr[0]), .fifo_full(full[0]), .frame_done(fd[0]),
    .frame_words(fw[0])
  );

  pack_512_wr #(.DIN_W(8), .CNT_W(16)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_data(dat[1][7:0]), .in_valid(valid[1]),
    .in_last(last[1]), .in_ready(ready[1]), .fifo_din(din[1]),
    .fifo_wr_en(wr[1]), .fifo_full(full[1]), .frame_done(fd[1]),
    .frame_words(fw[1])
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset(input int i);
    acc[i] = '0; nlane[i] = 0; exp_v[i] = 0; exp_word[i] = '0; exp_last[i] = 0;
    fd_due[i] = 0; exp_fw[i] = '0; wcnt[i] = 0;
  endtask

  // Compare one instance against the model, then advance the model by the
  // write and the input word that happen at the coming clock edge.
  task automatic check_inst(input int i);
    int          w     = (i == 0) ? 64 : 8;
    int          lanes = 512 / w;
    string       p     = (i == 0) ? "w64" : "w8";
    bit          wr_exp;
    logic [63:0] d;
    accepted[i] = 0;
    if (!rst_n) model_reset(i);
    wr_exp = exp_v[i] && !full[i];
    chk({p, "_in_ready"},    512'(ready[i]), 512'(!exp_v[i] || !full[i]));
    chk({p, "_wr_en"},       512'(wr[i]),    512'(wr_exp));
    chk({p, "_frame_done"},  512'(fd[i]),    512'(fd_due[i]));
    chk({p, "_frame_words"}, 512'(fw[i]),    512'(exp_fw[i]));
    if (!rst_n) begin
      chk({p, "_din_rst"}, din[i], '0);
      return;
    end
    if (wr[i] === 1'b1) begin
      nwr_dut[i]++;
      if (i == 0) wlog0.push_back(din[i]);
    end
    fd_due[i] = 0;
    if (wr_exp) begin
      chk({p, "_fifo_din"}, din[i], exp_word[i]);
      exp_v[i] = 0;
      if (exp_last[i]) begin
        exp_fw[i] = 16'(wcnt[i] + 1);
        wcnt[i]   = 0;
        fd_due[i] = 1;
      end else begin
        wcnt[i]++;
      end
    end
    if (valid[i] === 1'b1 && ready[i] === 1'b1) begin
      accepted[i] = 1;
      d = (i == 0) ? dat[0] : {56'b0, dat[1][7:0]};
      acc[i] = acc[i] | (512'(d) << (nlane[i] * w));
      nlane[i]++;
      if (nlane[i] == lanes || last[i]) begin
        exp_v[i]    = 1;
        exp_word[i] = acc[i];
        exp_last[i] = last[i];
        acc[i]      = '0;
        nlane[i]    = 0;
      end
    end
  endtask

  // One clock: check at the falling edge, update inputs just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (toggle_full[i]) begin
        full[i] = ~full[i];
      end else if (full_hold[i] > 0) begin
        full_hold[i]--;
        if (full_hold[i] == 0) full[i] = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    valid = '0;
    last  = '0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Present one word and hold it until accepted, within a cycle budget.
  task automatic send(input int i, input logic [63:0] d, input bit l);
    int n = 0;
    valid[i] = 1'b1;
    dat[i]   = d;
    last[i]  = l;
    do begin
      cycle();
      n++;
    end while (!accepted[i] && n < 200);
    chk($sformatf("w%0d_accept_timeout", (i == 0) ? 64 : 8), 512'(accepted[i]), 512'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0;
    valid = '0; last = '0; full = '0;
    dat[0] = '0; dat[1] = '0;
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      nwr_dut[i] = 0; full_hold[i] = 0; toggle_full[i] = 0;
    end
    @(posedge clk);
    #1;
    // Reset values are checked by the model while rst_n is low.
    for (int k = 0; k < 3; k++) cycle();
    rst_n = 1'b1;
    idle(2);

    // 16 words 0x1..0x10 back-to-back, last on the 16th: two full words.
    wlog0.delete();
    for (int k = 1; k <= 16; k++) send(0, 64'(k), k == 16);
    idle(3);
    chk("t1_writes", 512'(wlog0.size()), 512'(2));
    if (wlog0.size() == 2) begin
      chk("t1_w0_lane0", 512'(wlog0[0][63:0]),    512'(64'h1));
      chk("t1_w0_lane7", 512'(wlog0[0][511:448]), 512'(64'h8));
      chk("t1_w1_lane0", 512'(wlog0[1][63:0]),    512'(64'h9));
      chk("t1_w1_lane7", 512'(wlog0[1][511:448]), 512'(64'h10));
    end
    chk("t1_frame_words", 512'(fw[0]), 512'(2));

    // Three-word partial frame: zero-padded single write.
    wlog0.delete();
    send(0, 64'hA, 1'b0);
    send(0, 64'hB, 1'b0);
    send(0, 64'hC, 1'b1);
    idle(3);
    chk("t2_writes", 512'(wlog0.size()), 512'(1));
    if (wlog0.size() == 1) begin
      chk("t2_lane0", 512'(wlog0[0][63:0]),    512'(64'hA));
      chk("t2_lane1", 512'(wlog0[0][127:64]),  512'(64'hB));
      chk("t2_lane2", 512'(wlog0[0][191:128]), 512'(64'hC));
      chk("t2_pad",   512'(wlog0[0][511:192]), '0);
    end
    chk("t2_frame_words", 512'(fw[0]), 512'(1));

    // FIFO almost-full for 20 cycles while 24 words stream in.
    base = nwr_dut[0];
    full[0] = 1'b1;
    full_hold[0] = 20;
    for (int k = 0; k < 24; k++) send(0, {$urandom, $urandom}, 1'b0);
    idle(5);
    chk("t3_writes", 512'(nwr_dut[0] - base), 512'(3));

    // full toggling every cycle under continuous input.
    base = nwr_dut[0];
    toggle_full[0] = 1;
    for (int k = 0; k < 37; k++) send(0, {$urandom, $urandom}, k == 36);
    toggle_full[0] = 0;
    full[0] = 1'b0;
    idle(4);
    chk("t4_writes", 512'(nwr_dut[0] - base), 512'(5));

    // Reset after 5 of 8 words: nothing written; next 8 words form one clean word.
    base = nwr_dut[0];
    for (int k = 0; k < 5; k++) send(0, {$urandom, $urandom}, 1'b0);
    valid = '0;
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    idle(3);
    chk("t5_no_write", 512'(nwr_dut[0] - base), 512'(0));
    for (int k = 0; k < 8; k++) send(0, {$urandom, $urandom}, 1'b0);
    idle(3);
    chk("t5_one_write", 512'(nwr_dut[0] - base), 512'(1));

    // 8-bit input: 64-word frame, then 130 words with no frame end.
    base = nwr_dut[1];
    for (int k = 0; k < 64; k++) send(1, 64'($urandom_range(0, 255)), k == 63);
    idle(3);
    chk("t6_writes", 512'(nwr_dut[1] - base), 512'(1));
    chk("t6_frame_words", 512'(fw[1]), 512'(1));
    base = nwr_dut[1];
    for (int k = 0; k < 130; k++) send(1, 64'($urandom_range(0, 255)), 1'b0);
    idle(3);
    chk("t6_open_writes", 512'(nwr_dut[1] - base), 512'(2));
    chk("t6_words_held", 512'(fw[1]), 512'(1));

    // Random valid/last/full on both instances.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        valid[i] = ($urandom_range(0, 3) != 0);
        dat[i]   = {$urandom, $urandom};
        last[i]  = ($urandom_range(0, 15) == 0);
        full[i]  = ($urandom_range(0, 2) == 0);
      end
      cycle();
    end
    full = '0;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
